// File: rtl/serial_uart_fifo_if.sv
// Byte-stream handshake between the UART and the monitor: TX strobe/busy, RX FIFO head/pop, error flags.
// Latency: none, wires only.
// Backpressure: as_busy_o throttles TX requests; as_dstrb_o/as_rd_i form the RX pop handshake.
interface serial_uart_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] as_data_i;
    logic                 as_dstrb_i;
    logic                 as_busy_o;
    logic [DATA_BITS-1:0] as_data_o;
    logic                 as_dstrb_o;
    logic                 as_rd_i;
    logic                 as_err_clr_i;
    logic [2:0]           as_err_o;

    // The monitor side drives requests and pops.
    modport master (
        output as_data_i, as_dstrb_i, as_rd_i, as_err_clr_i,
        input  as_busy_o, as_data_o, as_dstrb_o, as_err_o
    );

    // The UART side answers them.
    modport slave (
        input  as_data_i, as_dstrb_i, as_rd_i, as_err_clr_i,
        output as_busy_o, as_data_o, as_dstrb_o, as_err_o
    );
endinterface

// File: rtl/serial_uart_fifo.sv
// Parametrised UART: TX serialiser, RX deserialiser with 2-flop synchroniser, FWFT RX FIFO, sticky errors.
// Latency: TX line leaves idle the cycle after the strobe; an RX word is visible the cycle after its stop sample.
// Backpressure: TX strobes are ignored while busy; RX words arriving at a full FIFO are dropped and flag overrun.
module serial_uart_fifo #(
    parameter int CLK_DIV       = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_DEPTH_LOG2 = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    output logic              serial_out,
    serial_uart_fifo_if.slave as_bus
);
    localparam logic [15:0] BIT_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic        PAR_ODD   = (PARITY == 2);
    localparam logic        HAS_PAR   = (PARITY != 0);
    localparam int          DEPTH     = 1 << RX_DEPTH_LOG2;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK} rx_state_t;

    // ---------------- TX ----------------
    tx_state_t            tx_state, tx_state_nxt;
    logic [15:0]          tx_cnt, tx_cnt_nxt;
    logic [3:0]           tx_bit, tx_bit_nxt;
    logic [DATA_BITS-1:0] tx_shr, tx_shr_nxt;
    logic                 tx_par, tx_par_nxt;
    logic                 tx_line, tx_line_nxt;
    logic                 tx_bit_end;

    // TX state register; reset forces the line high immediately, aborting any frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shr   <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shr   <= tx_shr_nxt;
            tx_par   <= tx_par_nxt;
            tx_line  <= tx_line_nxt;
        end
    end

    // TX sequencing: each bit held CLK_DIV cycles; the line value is registered from the next state.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shr_nxt   = tx_shr;
        tx_par_nxt   = tx_par;
        tx_line_nxt  = 1'b1;
        tx_bit_end   = (tx_cnt == BIT_LAST);
        case (tx_state)
            TX_IDLE: begin
                if (as_bus.as_dstrb_i) begin
                    tx_state_nxt = TX_START;
                    tx_shr_nxt   = as_bus.as_data_i;
                    tx_par_nxt   = (^as_bus.as_data_i) ^ PAR_ODD;
                    tx_cnt_nxt   = '0;
                end
            end
            TX_START: begin
                tx_cnt_nxt = tx_cnt + 16'd1;
                if (tx_bit_end) begin
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = '0;
                    tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_cnt_nxt = tx_cnt + 16'd1;
                if (tx_bit_end) begin
                    tx_cnt_nxt = '0;
                    tx_shr_nxt = tx_shr >> 1;
                    if (tx_bit == DATA_LAST) begin
                        tx_bit_nxt   = '0;
                        tx_state_nxt = HAS_PAR ? TX_PAR : TX_STOP;
                    end else begin
                        tx_bit_nxt = tx_bit + 4'd1;
                    end
                end
            end
            TX_PAR: begin
                tx_cnt_nxt = tx_cnt + 16'd1;
                if (tx_bit_end) begin
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = '0;
                    tx_state_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                tx_cnt_nxt = tx_cnt + 16'd1;
                if (tx_bit_end) begin
                    tx_cnt_nxt = '0;
                    if (tx_bit == STOP_LAST) begin
                        tx_bit_nxt   = '0;
                        tx_state_nxt = TX_IDLE;
                    end else begin
                        tx_bit_nxt = tx_bit + 4'd1;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
        case (tx_state_nxt)
            TX_START: tx_line_nxt = 1'b0;
            TX_DATA:  tx_line_nxt = tx_shr_nxt[0];
            TX_PAR:   tx_line_nxt = tx_par_nxt;
            default:  tx_line_nxt = 1'b1;
        endcase
    end

    assign serial_out       = tx_line;
    assign as_bus.as_busy_o = (tx_state != TX_IDLE);

    // ---------------- RX ----------------
    logic                 rx_s1, rx_s2, rx_s3;
    rx_state_t            rx_state, rx_state_nxt;
    logic [15:0]          rx_cnt, rx_cnt_nxt;
    logic [3:0]           rx_bit, rx_bit_nxt;
    logic [DATA_BITS-1:0] rx_shr, rx_shr_nxt;
    logic                 rx_push, rx_set_par, rx_set_frm;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= serial_in;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // RX state register; reset discards any partially assembled word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shr   <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shr   <= rx_shr_nxt;
        end
    end

    // RX sequencing: half-bit start qualification, then one mid-bit sample every CLK_DIV cycles.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shr_nxt   = rx_shr;
        rx_push      = 1'b0;
        rx_set_par   = 1'b0;
        rx_set_frm   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_s3 && !rx_s2) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = '0;
                    rx_bit_nxt   = '0;
                end
            end
            RX_START: begin
                rx_cnt_nxt = rx_cnt + 16'd1;
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                rx_cnt_nxt = rx_cnt + 16'd1;
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt = '0;
                    rx_shr_nxt = {rx_s2, rx_shr[DATA_BITS-1:1]};
                    if (rx_bit == DATA_LAST) begin
                        rx_bit_nxt   = '0;
                        rx_state_nxt = HAS_PAR ? RX_PAR : RX_STOP;
                    end else begin
                        rx_bit_nxt = rx_bit + 4'd1;
                    end
                end
            end
            RX_PAR: begin
                rx_cnt_nxt = rx_cnt + 16'd1;
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_set_par   = (rx_s2 != ((^rx_shr) ^ PAR_ODD));
                    rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                rx_cnt_nxt = rx_cnt + 16'd1;
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt = '0;
                    if (rx_s2) begin
                        rx_push      = 1'b1;
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_set_frm   = 1'b1;
                        rx_state_nxt = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rx_s2) rx_state_nxt = RX_IDLE;
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [RX_DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0]   mem [DEPTH];
    logic                   fifo_empty, fifo_full, fifo_pop, fifo_push, overrun;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[RX_DEPTH_LOG2] != rd_ptr[RX_DEPTH_LOG2]) &&
                        (wr_ptr[RX_DEPTH_LOG2-1:0] == rd_ptr[RX_DEPTH_LOG2-1:0]);
    assign fifo_pop   = as_bus.as_rd_i && !fifo_empty;
    // A same-cycle pop frees the slot a full FIFO needs.
    assign fifo_push  = rx_push && (!fifo_full || fifo_pop);
    assign overrun    = rx_push && fifo_full && !fifo_pop;

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until a word is pushed.
    always_ff @(posedge clk) begin
        if (fifo_push) mem[wr_ptr[RX_DEPTH_LOG2-1:0]] <= rx_shr;
    end

    assign as_bus.as_data_o  = mem[rd_ptr[RX_DEPTH_LOG2-1:0]];
    assign as_bus.as_dstrb_o = !fifo_empty;

    // ---------------- Errors ----------------
    logic [2:0] err;

    // Sticky {overrun, parity, framing}; a coincident set beats the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= '0;
        end else begin
            err <= (err & ~{3{as_bus.as_err_clr_i}}) | {overrun, rx_set_par, rx_set_frm};
        end
    end

    assign as_bus.as_err_o = err;
endmodule

// File: tb/tb_serial_uart_fifo.sv
// Self-checking bench: A = 8N1 loopback, B = 7O2 loopback with an injection override on its RX pin.
// Expected words go into per-instance queues at send time; monitors pop and compare as the DUT presents them.
// Frame timing, waveform, overrun, parity/framing errors, glitch rejection and mid-frame reset are covered.
module tb_serial_uart_fifo;
    localparam int DIV     = 16;
    localparam int FRAME_A = DIV * (1 + 8 + 0 + 1);
    localparam int FRAME_B = DIV * (1 + 7 + 1 + 2);
    localparam int DEPTH   = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    serial_uart_fifo_if #(.DATA_BITS(8)) bus_a();
    serial_uart_fifo_if #(.DATA_BITS(7)) bus_b();

    logic line_a;
    logic line_b_out, line_b_in;
    logic inj_en, inj_line;
    assign line_b_in = inj_en ? inj_line : line_b_out;

    serial_uart_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .RX_DEPTH_LOG2(3)) dut_a (
        .clk(clk), .reset(reset), .serial_in(line_a), .serial_out(line_a), .as_bus(bus_a)
    );
    serial_uart_fifo #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .RX_DEPTH_LOG2(3)) dut_b (
        .clk(clk), .reset(reset), .serial_in(line_b_in), .serial_out(line_b_out), .as_bus(bus_b)
    );

    logic [7:0] sb_a[$];
    logic [6:0] sb_b[$];
    logic [2:0] exp_err_a = '0;
    logic [2:0] exp_err_b = '0;
    bit pop_en_a = 1'b1;
    bit pop_en_b = 1'b1;
    bit pop_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // Monitor A: pop and compare whenever the FIFO presents a word.
    initial begin
        bus_a.as_rd_i = 1'b0;
        forever begin
            @(negedge clk);
            bus_a.as_rd_i = 1'b0;
            if (reset && pop_en_a && bus_a.as_dstrb_o && (!pop_rand || $urandom_range(1, 0) == 1)) begin
                if (sb_a.size() == 0) fail("a_unexpected_word");
                else check("a_rx_word", 32'(bus_a.as_data_o), 32'(sb_a.pop_front()));
                bus_a.as_rd_i = 1'b1;
            end
        end
    end

    // Monitor B.
    initial begin
        bus_b.as_rd_i = 1'b0;
        forever begin
            @(negedge clk);
            bus_b.as_rd_i = 1'b0;
            if (reset && pop_en_b && bus_b.as_dstrb_o && (!pop_rand || $urandom_range(1, 0) == 1)) begin
                if (sb_b.size() == 0) fail("b_unexpected_word");
                else check("b_rx_word", 32'(bus_b.as_data_o), 32'(sb_b.pop_front()));
                bus_b.as_rd_i = 1'b1;
            end
        end
    end

    // Busy-length monitors: every completed frame lasts exactly one frame time.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) cnt = 0;
            else if (bus_a.as_busy_o) cnt++;
            else if (cnt != 0) begin
                check("a_busy_len", 32'(cnt), 32'(FRAME_A));
                cnt = 0;
            end
        end
    end

    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) cnt = 0;
            else if (bus_b.as_busy_o) cnt++;
            else if (cnt != 0) begin
                check("b_busy_len", 32'(cnt), 32'(FRAME_B));
                cnt = 0;
            end
        end
    end

    // Returns on the first negedge after acceptance (first START cycle).
    task automatic send_a(input logic [7:0] w, input bit expect_rx);
        int t = 0;
        @(negedge clk);
        while (bus_a.as_busy_o && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) fail("a_send_timeout");
        bus_a.as_data_i  = w;
        bus_a.as_dstrb_i = 1'b1;
        if (expect_rx) begin
            if (sb_a.size() < DEPTH) sb_a.push_back(w);
            else exp_err_a[2] = 1'b1;
        end
        @(negedge clk);
        bus_a.as_dstrb_i = 1'b0;
    endtask

    task automatic send_b(input logic [6:0] w);
        int t = 0;
        @(negedge clk);
        while (bus_b.as_busy_o && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) fail("b_send_timeout");
        bus_b.as_data_i  = w;
        bus_b.as_dstrb_i = 1'b1;
        sb_b.push_back(w);
        @(negedge clk);
        bus_b.as_dstrb_i = 1'b0;
    endtask

    task automatic drain_all();
        int t = 0;
        while ((sb_a.size() != 0 || sb_b.size() != 0 || bus_a.as_busy_o || bus_b.as_busy_o) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) fail("drain_timeout");
        repeat (20) @(negedge clk);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        bus_a.as_err_clr_i = 1'b1;
        bus_b.as_err_clr_i = 1'b1;
        @(negedge clk);
        bus_a.as_err_clr_i = 1'b0;
        bus_b.as_err_clr_i = 1'b0;
        exp_err_a = '0;
        exp_err_b = '0;
        @(negedge clk);
    endtask

    // Drive a 7O2 frame onto B's RX pin, optionally with wrong parity or a low stop bit.
    task automatic inj_frame(input logic [6:0] w, input bit bad_par, input bit bad_stop);
        inj_line = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            inj_line = w[i];
            repeat (DIV) @(negedge clk);
        end
        inj_line = (^w) ^ 1'b1 ^ bad_par;
        repeat (DIV) @(negedge clk);
        if (bad_stop) begin
            inj_line = 1'b0;
            repeat (4 * DIV) @(negedge clk);
            check("b_break_no_word", 32'(bus_b.as_dstrb_o), 32'd0);
            check("b_break_frm_flag", 32'(bus_b.as_err_o[0]), 32'd1);
        end
        inj_line = 1'b1;
        repeat (2 * DIV) @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] wave;
        logic        got;
        bit          bad;
        bus_a.as_data_i = '0; bus_a.as_dstrb_i = 1'b0; bus_a.as_err_clr_i = 1'b0;
        bus_b.as_data_i = '0; bus_b.as_dstrb_i = 1'b0; bus_b.as_err_clr_i = 1'b0;
        inj_en = 1'b0;
        inj_line = 1'b1;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_a_line", 32'(line_a), 32'd1);
        check("rst_a_busy", 32'(bus_a.as_busy_o), 32'd0);
        check("rst_a_dstrb", 32'(bus_a.as_dstrb_o), 32'd0);
        check("rst_a_err", 32'(bus_a.as_err_o), 32'd0);
        check("rst_b_line", 32'(line_b_out), 32'd1);
        check("rst_b_busy", 32'(bus_b.as_busy_o), 32'd0);
        check("rst_b_dstrb", 32'(bus_b.as_dstrb_o), 32'd0);
        check("rst_b_err", 32'(bus_b.as_err_o), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1 loopback, every byte value back to back.
        for (int v = 0; v < 256; v++) send_a(8'(v), 1'b1);
        drain_all();
        check("a_sweep_err", 32'(bus_a.as_err_o), 32'(exp_err_a));

        // 7O2 waveform for 0x55: start, 1010101 LSB first, odd parity 1, two stops.
        send_b(7'h55);
        wave = 11'b11_1_1010101_0;
        for (int b = 0; b < 11; b++) begin
            bad = 1'b0;
            got = line_b_out;
            for (int c = 0; c < DIV; c++) begin
                if (line_b_out !== wave[b]) begin
                    bad = 1'b1;
                    got = line_b_out;
                end
                @(negedge clk);
            end
            check($sformatf("b_wave_bit%0d", b), 32'(got), 32'(wave[b]));
            if (bad) $display("  bit %0d not stable for %0d cycles", b, DIV);
        end
        drain_all();
        check("b_55_err", 32'(bus_b.as_err_o), 32'd0);

        // Overrun: ten words with no pops keeps only the first eight.
        pop_en_a = 1'b0;
        for (int v = 1; v <= 10; v++) send_a(8'(v), 1'b1);
        repeat (FRAME_A) @(negedge clk);
        check("a_ovr_dstrb", 32'(bus_a.as_dstrb_o), 32'd1);
        check("a_ovr_err", 32'(bus_a.as_err_o), 32'(exp_err_a));
        check("a_ovr_sb_len", 32'(sb_a.size()), 32'd8);
        pop_en_a = 1'b1;
        drain_all();
        check("a_ovr_empty", 32'(bus_a.as_dstrb_o), 32'd0);
        check("a_ovr_sticky", 32'(bus_a.as_err_o), 32'b100);
        clr_pulse();
        check("a_ovr_cleared", 32'(bus_a.as_err_o), 32'd0);

        // Injected frames on B: bad parity, then bad stop + break, then a good frame.
        inj_en = 1'b1;
        inj_line = 1'b1;
        repeat (5) @(negedge clk);
        sb_b.push_back(7'h2A);
        exp_err_b[1] = 1'b1;
        inj_frame(7'h2A, 1'b1, 1'b0);
        drain_all();
        check("b_par_err", 32'(bus_b.as_err_o), 32'(exp_err_b));
        clr_pulse();
        check("b_par_cleared", 32'(bus_b.as_err_o), 32'd0);
        exp_err_b[0] = 1'b1;
        inj_frame(7'h13, 1'b0, 1'b1);
        check("b_frm_err", 32'(bus_b.as_err_o), 32'(exp_err_b));
        sb_b.push_back(7'h6C);
        inj_frame(7'h6C, 1'b0, 1'b0);
        drain_all();
        check("b_after_break_err", 32'(bus_b.as_err_o), 32'(exp_err_b));
        clr_pulse();

        // Short glitch on an idle line must be rejected silently.
        inj_line = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        inj_line = 1'b1;
        repeat (4 * DIV) @(negedge clk);
        check("b_glitch_no_word", 32'(bus_b.as_dstrb_o), 32'd0);
        check("b_glitch_no_err", 32'(bus_b.as_err_o), 32'd0);
        inj_en = 1'b0;
        repeat (5) @(negedge clk);

        // Random words on both instances with random pop backpressure.
        pop_rand = 1'b1;
        fork
            for (int i = 0; i < 30; i++) send_a(8'($urandom), 1'b1);
            for (int i = 0; i < 20; i++) send_b(7'($urandom));
        join
        drain_all();
        pop_rand = 1'b0;
        check("rand_a_err", 32'(bus_a.as_err_o), 32'd0);
        check("rand_b_err", 32'(bus_b.as_err_o), 32'd0);

        // Reset during data bit 3 of 0xC3 (line low there) aborts the frame at once.
        send_a(8'hC3, 1'b0);
        repeat (DIV * 4 + DIV / 2 - 1) @(negedge clk);
        check("a_mid_bit3_low", 32'(line_a), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("a_rst_line_async", 32'(line_a), 32'd1);
        check("a_rst_busy_async", 32'(bus_a.as_busy_o), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_err_a = '0;
        exp_err_b = '0;
        repeat (3) @(negedge clk);
        check("a_post_rst_dstrb", 32'(bus_a.as_dstrb_o), 32'd0);
        send_a(8'hA5, 1'b1);
        drain_all();
        check("a_post_rst_err", 32'(bus_a.as_err_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_uart_fifo.md
Name: serial_uart_fifo

Overview:
- Parametrised successor to the fixed-format serial UART used by the monitor.
- Generalised in data width, parity mode, stop-bit count and bit period.
- Adds an RX FIFO with a pop handshake and sticky framing/parity/overrun error flags.
- Sits between the external serial pins and the monitor's as_* byte-stream interface. A TX loopback (serial_out tied to serial_in) must round-trip every word.

Parameters:
CLK_DIV, 16, clock cycles per bit period; legal range 4..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, 1 or 2 stop bits (TX sends this many; RX checks the first only).
RX_DEPTH_LOG2, 3, RX FIFO depth = 2**RX_DEPTH_LOG2 words.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
serial_in  input  1  RX line, asynchronous to clk; idles high.
serial_out  output  1  TX line; idles high.
as_data_i  input  DATA_BITS  TX word.
as_dstrb_i  input  1  TX request; sampled only while as_busy_o=0.
as_busy_o  output  1  TX frame in progress.
as_data_o  output  DATA_BITS  RX FIFO head word (first-word-fall-through).
as_dstrb_o  output  1  RX FIFO non-empty; as_data_o is valid.
as_rd_i  input  1  pop the FIFO head; ignored when as_dstrb_o=0.
as_err_clr_i  input  1  clears all sticky error flags.
as_err_o  output  3  sticky flags {overrun, parity, framing}.

Behaviour:
Reset values
- serial_out=1, as_busy_o=0, as_dstrb_o=0, as_err_o=0.
- FIFO empty; both FSMs in IDLE; all counters 0.
- as_data_o is don't-care while empty.
- Reset asserted mid-frame aborts immediately. serial_out returns to 1 asynchronously and any partial RX word is discarded.

TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- In IDLE with as_dstrb_i=1: latch as_data_i. as_busy_o=1 from the next cycle, with serial_out=0 (START) on the same cycle.
- Each state bit is held exactly CLK_DIV cycles.
- Data is sent LSB first. Parity bit = XOR of the data bits (even) or its inverse (odd).
- STOP lasts STOP_BITS*CLK_DIV cycles, then IDLE with as_busy_o=0.
- Frame length in cycles = CLK_DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS).
- The earliest next strobe is accepted on the cycle as_busy_o=0 is seen, so back-to-back frames carry no idle gap.
- as_dstrb_i while busy is ignored and not queued.

RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> (IDLE | BREAK).
- serial_in passes through a 2-flop synchroniser; all RX timing is relative to the synchronised signal.
- IDLE: a synchronised 1->0 transition enters START and loads the bit counter.
- START: after CLK_DIV/2 cycles (integer division), resample. If 1, treat as a glitch and return to IDLE with nothing recorded. If 0, proceed.
- DATA, PARITY and STOP are each sampled CLK_DIV cycles after the previous sample point (mid-bit).
- Parity mismatch: the word is still pushed and the parity flag is set.
- Stop sample 0: set the framing flag, do not push the word, enter BREAK. BREAK waits for the line to be 1 before returning to IDLE.
- Stop sample 1: push the word and return to IDLE immediately; no second-stop check, which allows resync on the next edge.

FIFO
- Push occurs on the stop-sample cycle.
- Push while full: the word is dropped, the overrun flag is set, and contents are unchanged.
- Push and pop in the same cycle while full: the pop frees a slot, so the push succeeds and no overrun is flagged.
- Push and pop in the same cycle while empty: the push occurs; the pop is ignored.
- Latency: as_dstrb_o=1 and as_data_o valid on the cycle after the push.
- Pop: the head advances on the cycle after as_rd_i=1.
- Pointers are RX_DEPTH_LOG2+1 bits and wrap naturally; full/empty are derived from the MSB compare.

Errors
- Flags are sticky until as_err_clr_i=1 (cleared on the next cycle).
- If a set event and a clear coincide, the set wins.

Test Plan:
- Loopback, defaults (CLK_DIV=16, 8N1): send 0x00..0xFF back-to-back -> 256 words popped in order, each frame 160 cycles of as_busy_o, as_err_o=0 throughout.
- DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x55 -> serial_out low 16 cycles, then 1,0,1,0,1,0,1, then parity 1, then 32 cycles high; RX returns 0x55.
- Overrun, RX_DEPTH_LOG2=3: send 10 words with no pops -> as_dstrb_o=1, as_err_o=3'b100, pops return words 1..8 only. as_err_clr_i pulse -> 0.
- Corrupt the parity bit on an injected frame -> word delivered, as_err_o=3'b010. Force the stop bit low -> no word pushed, as_err_o[0]=1, RX waits in BREAK until the line returns high, and the next good frame is received.
- Injected 0-pulse of CLK_DIV/4 cycles on an idle serial_in -> no word, no error.
- reset=0 mid-TX at bit 3 -> serial_out=1 immediately. After release, the next as_dstrb_i sends a clean frame.
